// File: rtl/fp_pkg.sv
// fp_pkg: shared binary64 constants, operand classes and the fp_mul_seq
// state encoding. Imported by fp_mul_seq_if, mant_mul_iter and fp_mul_seq.
package fp_pkg;

  localparam logic [63:0] FP_QNAN     = 64'h7FF8_0000_0000_0000;
  localparam int          FP_EXP_BIAS = 1023;
  localparam int          FP_EXP_MAX  = 2047;
  localparam int          FP_EXP_W    = 11;
  localparam int          FP_FRAC_W   = 52;
  localparam int          FP_MANT_W   = 53;   // fraction plus hidden bit
  localparam int          FP_PROD_W   = 106;

  typedef enum logic [1:0] {
    CLS_ZERO,
    CLS_NORMAL,
    CLS_INF,
    CLS_NAN
  } fp_class_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_UNPACK,
    S_MUL,
    S_NORM,
    S_PACK
  } fp_mul_state_e;

  // Subnormals (exp==0, frac!=0) are classified as zero: inputs are flushed.
  function automatic fp_class_e fp_classify(input logic [63:0] x);
    logic [FP_EXP_W-1:0]  e;
    logic [FP_FRAC_W-1:0] f;
    e = x[62:52];
    f = x[51:0];
    if (e == '0)      return CLS_ZERO;
    else if (e == '1) return (f != '0) ? CLS_NAN : CLS_INF;
    else              return CLS_NORMAL;
  endfunction

endpackage

// File: rtl/fp_mul_seq_if.sv
// fp_mul_seq_if: valid/finish arithmetic-unit handshake.
//   master (CMU FSM side): drives valid, a, b; observes finish, result, busy.
//   slave  (multiplier)  : the reverse.
// With FP_MUL_FLAGS_EN defined, adds flags[3:0] = {invalid, overflow,
// underflow, inexact}, driven by the slave.
interface fp_mul_seq_if #(
  parameter int DBL_WIDTH = 64
);
  import fp_pkg::*;

  logic                 valid;
  logic [DBL_WIDTH-1:0] a;
  logic [DBL_WIDTH-1:0] b;
  logic                 finish;
  logic [DBL_WIDTH-1:0] result;
  logic                 busy;
`ifdef FP_MUL_FLAGS_EN
  logic [3:0]           flags;

  modport master (output valid, a, b, input finish, result, busy, flags);
  modport slave  (input valid, a, b, output finish, result, busy, flags);
`else
  modport master (output valid, a, b, input finish, result, busy);
  modport slave  (input valid, a, b, output finish, result, busy);
`endif

endinterface

// File: rtl/mant_mul_iter.sv
// mant_mul_iter: 53x53 unsigned iterative multiplier, BPC multiplier bits
// retired per cycle, ITER = ceil(53/BPC) cycles including the start cycle.
//   clk, rst_n : clock, asynchronous active-low reset
//   i_start    : load operands and retire the first BPC-bit digit
//   i_a, i_b   : multiplicand, multiplier
//   o_done     : one-cycle pulse, o_product valid and held from then on
//   o_product  : 106-bit product
module mant_mul_iter
  import fp_pkg::*;
#(
  parameter int BPC = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_start,
  input  logic [FP_MANT_W-1:0] i_a,
  input  logic [FP_MANT_W-1:0] i_b,
  output logic                 o_done,
  output logic [FP_PROD_W-1:0] o_product
);

  localparam int ITER  = (FP_MANT_W + BPC - 1) / BPC;
  localparam int CNT_W = $clog2(ITER + 1);

  logic [FP_PROD_W-1:0] r_acc;
  logic [FP_PROD_W-1:0] r_mcand;
  logic [FP_MANT_W-1:0] r_mplier;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_done;

  logic [FP_PROD_W-1:0] w_a_ext;
  logic [FP_PROD_W-1:0] w_pp_first;
  logic [FP_PROD_W-1:0] w_pp;

  // The multiplicand is kept pre-shifted in a 106-bit register; bits shifted
  // out are harmless because the true product always fits in 106 bits.
  always_comb begin
    w_a_ext    = {{(FP_PROD_W-FP_MANT_W){1'b0}}, i_a};
    w_pp_first = w_a_ext * {{(FP_PROD_W-BPC){1'b0}}, i_b[BPC-1:0]};
    w_pp       = r_mcand * {{(FP_PROD_W-BPC){1'b0}}, r_mplier[BPC-1:0]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_start) begin
        r_acc    <= w_pp_first;
        r_mcand  <= w_a_ext << BPC;
        r_mplier <= i_b >> BPC;
        r_cnt    <= CNT_W'(ITER - 1);
      end else if (r_cnt != '0) begin
        r_acc    <= r_acc + w_pp;
        r_mcand  <= r_mcand << BPC;
        r_mplier <= r_mplier >> BPC;
        r_cnt    <= r_cnt - 1'b1;
        if (r_cnt == CNT_W'(1)) r_done <= 1'b1;
      end
    end
  end

  assign o_done    = r_done;
  assign o_product = r_acc;

endmodule

// File: rtl/fp_mul_seq.sv
// fp_mul_seq: IEEE-754 binary64 multiplier, fixed latency ITER+3 cycles from
// the accepting edge (ITER = ceil(53/BPC)), one operation in flight.
// RNE rounding, flush-to-zero on subnormal inputs and underflow.
//   clk   : clock
//   rst_n : asynchronous active-low reset, discards any operation in flight
//   bus   : fp_mul_seq_if slave (valid, a, b -> finish, result, busy)
// Optional macro FP_MUL_FLAGS_EN adds bus.flags = {invalid, overflow,
// underflow, inexact}, registered with result.
module fp_mul_seq
  import fp_pkg::*;
#(
  parameter int DBL_WIDTH = 64,
  parameter int BPC       = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  fp_mul_seq_if.slave  bus
);

  fp_mul_state_e r_state, w_next;

  logic [DBL_WIDTH-1:0] r_a, r_b, r_result;
  logic                 r_finish, r_sign;
  fp_class_e            r_cls_a, r_cls_b;
  logic signed [12:0]   r_exp;
  logic [FP_MANT_W-1:0] r_mant;
  logic                 r_guard, r_sticky;

  logic                 w_accept, w_mul_start, w_mul_done;
  logic [FP_PROD_W-1:0] w_prod;
  logic signed [12:0]   w_exp_sum, w_exp_fin;
  logic                 w_round_up, w_ovf, w_udf, w_any_nan, w_any_inf, w_any_zero;
  logic [FP_MANT_W:0]   w_mant_rnd;
  logic [FP_FRAC_W-1:0] w_frac;
  logic [DBL_WIDTH-1:0] w_pack;
`ifdef FP_MUL_FLAGS_EN
  logic                 r_snan;
  logic [3:0]           r_flags, w_pack_flags;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    w_accept    = 1'b0;
    w_mul_start = 1'b0;
    case (r_state)
      S_IDLE: if (bus.valid) begin
        w_accept = 1'b1;
        w_next   = S_UNPACK;
      end
      S_UNPACK: begin
        w_mul_start = 1'b1;
        w_next      = S_MUL;
      end
      S_MUL:    if (w_mul_done) w_next = S_NORM;
      S_NORM:   w_next = S_PACK;
      S_PACK:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  mant_mul_iter #(.BPC(BPC)) u_mant_mul (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_start   (w_mul_start),
    .i_a       ({1'b1, r_a[51:0]}),
    .i_b       ({1'b1, r_b[51:0]}),
    .o_done    (w_mul_done),
    .o_product (w_prod)
  );

  // Exponent sum, rounding and final packing (consumed in UNPACK / PACK).
  always_comb begin
    w_exp_sum  = $signed({2'b00, r_a[62:52]}) + $signed({2'b00, r_b[62:52]})
               - $signed(13'(FP_EXP_BIAS));
    w_round_up = r_guard & (r_sticky | r_mant[0]);
    w_mant_rnd = {1'b0, r_mant} + {{FP_MANT_W{1'b0}}, w_round_up};
    // A rounding carry-out makes the mantissa exactly 2.0: renormalise.
    w_exp_fin  = r_exp + $signed({12'b0, w_mant_rnd[FP_MANT_W]});
    w_frac     = w_mant_rnd[FP_MANT_W] ? w_mant_rnd[FP_FRAC_W:1] : w_mant_rnd[FP_FRAC_W-1:0];
    w_ovf      = (w_exp_fin >= $signed(13'(FP_EXP_MAX)));
    w_udf      = (w_exp_fin <= 13'sd0);
    w_any_nan  = (r_cls_a == CLS_NAN)  || (r_cls_b == CLS_NAN);
    w_any_inf  = (r_cls_a == CLS_INF)  || (r_cls_b == CLS_INF);
    w_any_zero = (r_cls_a == CLS_ZERO) || (r_cls_b == CLS_ZERO);
    if (w_any_nan || (w_any_inf && w_any_zero)) w_pack = FP_QNAN;
    else if (w_any_inf)                         w_pack = {r_sign, 11'h7FF, 52'b0};
    else if (w_any_zero)                        w_pack = {r_sign, 63'b0};
    else if (w_ovf)                             w_pack = {r_sign, 11'h7FF, 52'b0};
    else if (w_udf)                             w_pack = {r_sign, 63'b0};
    else                                        w_pack = {r_sign, w_exp_fin[10:0], w_frac};
`ifdef FP_MUL_FLAGS_EN
    w_pack_flags    = '0;
    w_pack_flags[3] = r_snan || (!w_any_nan && w_any_inf && w_any_zero);
    if (!w_any_nan && !w_any_inf && !w_any_zero) begin
      w_pack_flags[2] = w_ovf;
      w_pack_flags[1] = w_udf && !w_ovf;
      w_pack_flags[0] = r_guard | r_sticky | w_ovf | w_udf;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_result <= '0;
      r_finish <= 1'b0;
      r_sign   <= 1'b0;
      r_cls_a  <= CLS_ZERO;
      r_cls_b  <= CLS_ZERO;
      r_exp    <= '0;
      r_mant   <= '0;
      r_guard  <= 1'b0;
      r_sticky <= 1'b0;
`ifdef FP_MUL_FLAGS_EN
      r_snan   <= 1'b0;
      r_flags  <= '0;
`endif
    end else begin
      r_finish <= 1'b0;
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_a <= bus.a;
          r_b <= bus.b;
        end
        S_UNPACK: begin
          r_sign  <= r_a[63] ^ r_b[63];
          r_cls_a <= fp_classify(r_a);
          r_cls_b <= fp_classify(r_b);
          r_exp   <= w_exp_sum;
`ifdef FP_MUL_FLAGS_EN
          r_snan  <= ((fp_classify(r_a) == CLS_NAN) && !r_a[51])
                  || ((fp_classify(r_b) == CLS_NAN) && !r_b[51]);
`endif
        end
        S_NORM: begin
          if (w_prod[105]) begin
            r_mant   <= w_prod[105:53];
            r_guard  <= w_prod[52];
            r_sticky <= |w_prod[51:0];
            r_exp    <= r_exp + 13'sd1;
          end else begin
            r_mant   <= w_prod[104:52];
            r_guard  <= w_prod[51];
            r_sticky <= |w_prod[50:0];
          end
        end
        S_PACK: begin
          r_result <= w_pack;
          r_finish <= 1'b1;
`ifdef FP_MUL_FLAGS_EN
          r_flags  <= w_pack_flags;
`endif
        end
        default: ;
      endcase
    end
  end

  assign bus.finish = r_finish;
  assign bus.result = r_result;
  assign bus.busy   = (r_state != S_IDLE);
`ifdef FP_MUL_FLAGS_EN
  assign bus.flags  = r_flags;
`endif

endmodule

// File: tb/tb_fp_mul_seq.sv
// tb_fp_mul_seq: directed-vector bench for fp_mul_seq (BPC=4, latency 17).
module tb_fp_mul_seq;

  localparam int LAT = 17;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  fp_mul_seq_if #(.DBL_WIDTH(64)) bus ();

  fp_mul_seq #(.DBL_WIDTH(64), .BPC(4)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Caller is at a negedge; valid is sampled on the following posedge.
  task automatic start_op(input logic [63:0] a, input logic [63:0] b);
    bus.valid = 1'b1;
    bus.a     = a;
    bus.b     = b;
    @(negedge clk);
    bus.valid = 1'b0;
  endtask

  // Counts negedges after the accepting edge until finish (bounded).
  task automatic wait_finish(input string tag, output int lat);
    int bad_busy;
    bad_busy = (bus.busy !== 1'b1) ? 1 : 0;
    lat = -1;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (bus.finish === 1'b1) begin
        lat = k;
        if (bus.busy !== 1'b0) bad_busy++;
        break;
      end
      if (bus.busy !== 1'b1) bad_busy++;
    end
    check({tag, " latency"}, 64'(lat), 64'(LAT));
    check({tag, " busy"}, 64'(bad_busy), 64'd0);
  endtask

  task automatic do_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] exp, input logic [3:0] exp_flags);
    int lat;
    start_op(a, b);
    wait_finish(tag, lat);
    check({tag, " result"}, bus.result, exp);
`ifdef FP_MUL_FLAGS_EN
    check({tag, " flags"}, 64'(bus.flags), 64'(exp_flags));
`else
    if (exp_flags === 4'hx) $display("unreachable");
`endif
    @(negedge clk);
    check({tag, " finish width"}, 64'(bus.finish), 64'd0);
    check({tag, " held"}, bus.result, exp);
  endtask

  initial begin
    int lat;
    int n_fin;
    bus.valid = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    repeat (3) @(negedge clk);
    check("reset result", bus.result, 64'd0);
    check("reset finish", 64'(bus.finish), 64'd0);
    check("reset busy", 64'(bus.busy), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    do_op("3*2.5",  64'h4008_0000_0000_0000, 64'h4004_0000_0000_0000, 64'h401E_0000_0000_0000, 4'b0000);
    do_op("-2*3",   64'hC000_0000_0000_0000, 64'h4008_0000_0000_0000, 64'hC018_0000_0000_0000, 4'b0000);
    do_op("rne",    64'h3FF0_0000_0000_0001, 64'h3FF0_0000_0000_0001, 64'h3FF0_0000_0000_0002, 4'b0001);
    do_op("inf*0",  64'h7FF0_0000_0000_0000, 64'h0000_0000_0000_0000, 64'h7FF8_0000_0000_0000, 4'b1000);
    do_op("nan*1",  64'h7FF8_0000_0000_0001, 64'h3FF0_0000_0000_0000, 64'h7FF8_0000_0000_0000, 4'b0000);
    do_op("-0*5",   64'h8000_0000_0000_0000, 64'h4014_0000_0000_0000, 64'h8000_0000_0000_0000, 4'b0000);
    do_op("ovf",    64'h7FE0_0000_0000_0000, 64'h4000_0000_0000_0000, 64'h7FF0_0000_0000_0000, 4'b0101);
    do_op("udf",    64'h0010_0000_0000_0000, 64'h3FE0_0000_0000_0000, 64'h0000_0000_0000_0000, 4'b0011);
    do_op("snan*2", 64'h7FF0_0000_0000_0001, 64'h4000_0000_0000_0000, 64'h7FF8_0000_0000_0000, 4'b1000);

    // valid re-pulsed while busy must be ignored
    start_op(64'h4008_0000_0000_0000, 64'h4004_0000_0000_0000);
    n_fin = 0;
    lat   = -1;
    for (int k = 1; k <= 45; k++) begin
      if (k == 5) begin
        bus.valid = 1'b1;
        bus.a     = 64'h3FF0_0000_0000_0000;
        bus.b     = 64'h3FF0_0000_0000_0000;
      end else begin
        bus.valid = 1'b0;
      end
      @(negedge clk);
      if (bus.finish === 1'b1) begin
        n_fin++;
        if (lat < 0) lat = k;
      end
    end
    check("ignore count", 64'(n_fin), 64'd1);
    check("ignore latency", 64'(lat), 64'(LAT));
    check("ignore result", bus.result, 64'h401E_0000_0000_0000);

    // valid in the finish cycle is accepted
    start_op(64'h4008_0000_0000_0000, 64'h4004_0000_0000_0000);
    wait_finish("b2b first", lat);
    start_op(64'hC000_0000_0000_0000, 64'h4008_0000_0000_0000);
    wait_finish("b2b second", lat);
    check("b2b result", bus.result, 64'hC018_0000_0000_0000);
    @(negedge clk);

    // asynchronous reset mid-operation
    start_op(64'h4008_0000_0000_0000, 64'h4004_0000_0000_0000);
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst finish", 64'(bus.finish), 64'd0);
    check("rst busy", 64'(bus.busy), 64'd0);
    check("rst result", bus.result, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    n_fin = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (bus.finish === 1'b1 || bus.busy === 1'b1) n_fin++;
    end
    check("rst no stale", 64'(n_fin), 64'd0);
    do_op("after rst", 64'hC000_0000_0000_0000, 64'h4008_0000_0000_0000, 64'hC018_0000_0000_0000, 4'b0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
